// File: rtl/bru_pkg.sv
// Shared types for the branch resolution stage: compare codes, link offset, result flags.
package bru_pkg;

   typedef enum logic [2:0] {
      EQ  = 3'b000,
      NE  = 3'b001,
      LT  = 3'b100,
      GE  = 3'b101,
      LTU = 3'b110,
      GEU = 3'b111
   } bcu_op_e;

   localparam int LINK_OFFSET = 4;

   typedef struct packed {
      logic taken;
      logic mispredict;
      logic illegal;
   } bru_flags_t;

endpackage

// File: rtl/bru_cmp.sv
// Conditional-branch comparator: funct3 code and two operands in, taken/illegal out.
// Purely combinational; no handshake.
module bru_cmp
   import bru_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  bcu_op_e         op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            taken,
   output logic            illegal
);

   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (op)
         EQ:      taken = (rs1 == rs2);
         NE:      taken = (rs1 != rs2);
         LT:      taken = ($signed(rs1) <  $signed(rs2));
         GE:      taken = ($signed(rs1) >= $signed(rs2));
         LTU:     taken = (rs1 <  rs2);
         GEU:     taken = (rs1 >= rs2);
         // 010/011 have no compare meaning
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branches/JAL/JALR, checks the front-end prediction and counts retirements.
// Latency 1 cycle; single registered stage, ready_o = !valid_o | ready_i, payload held while stalled.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [XLEN-1:0]  rs1_i,
   input  logic [XLEN-1:0]  rs2_i,
   input  logic [XLEN-1:0]  pc_i,
   input  logic [XLEN-1:0]  imm_i,
   input  logic [2:0]       bcu_op_i,
   input  logic             is_jal_i,
   input  logic             is_jalr_i,
   input  logic             pred_taken_i,
   input  logic [XLEN-1:0]  pred_target_i,
   input  logic             flush_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             taken_o,
   output logic [XLEN-1:0]  target_o,
   output logic [XLEN-1:0]  link_o,
   output logic             mispredict_o,
   output logic [XLEN-1:0]  redirect_pc_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] br_cnt_o,
   output logic [CNT_W-1:0] miss_cnt_o
);

   typedef struct packed {
      logic [XLEN-1:0] target;
      logic [XLEN-1:0] link;
      logic [XLEN-1:0] redirect_pc;
      bru_flags_t      flags;
   } res_t;

   localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

   logic             cmp_taken;
   logic             cmp_illegal;
   logic             is_jump;
   res_t             res_d;
   res_t             res_q;
   logic             valid_q;
   logic             load;
   logic             retire;
   logic [CNT_W-1:0] br_cnt_q;
   logic [CNT_W-1:0] miss_cnt_q;

   bru_cmp #(.XLEN(XLEN)) u_cmp (
      .op      (bcu_op_e'(bcu_op_i)),
      .rs1     (rs1_i),
      .rs2     (rs2_i),
      .taken   (cmp_taken),
      .illegal (cmp_illegal)
   );

   assign is_jump = is_jal_i | is_jalr_i;

   always_comb begin
      res_d                  = '0;
      res_d.flags.taken      = is_jump | cmp_taken;
      res_d.flags.illegal    = ~is_jump & cmp_illegal;
      // JALR takes priority when both jump flags are raised
      res_d.target           = is_jalr_i ? ((rs1_i + imm_i) & JALR_MASK) : (pc_i + imm_i);
      res_d.link             = pc_i + XLEN'(LINK_OFFSET);
      res_d.flags.mispredict = (res_d.flags.taken != pred_taken_i) |
                               (res_d.flags.taken & (res_d.target != pred_target_i));
      res_d.redirect_pc      = res_d.flags.taken ? res_d.target : res_d.link;
   end

   assign ready_o = ~valid_q | ready_i;
   assign load    = valid_i & ready_o & ~flush_i;
   assign retire  = valid_q & ready_i & ~flush_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q    <= 1'b0;
         res_q      <= '0;
         br_cnt_q   <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (load) begin
            valid_q <= 1'b1;
            res_q   <= res_d;
         end else if (flush_i | ready_i) begin
            valid_q <= 1'b0;
         end
         if (retire) begin
            if (br_cnt_q != '1)
               br_cnt_q <= br_cnt_q + CNT_W'(1);
            if (res_q.flags.mispredict && (miss_cnt_q != '1))
               miss_cnt_q <= miss_cnt_q + CNT_W'(1);
         end
      end
   end

   assign valid_o       = valid_q;
   assign taken_o       = res_q.flags.taken;
   assign target_o      = res_q.target;
   assign link_o        = res_q.link;
   assign mispredict_o  = res_q.flags.mispredict;
   assign redirect_pc_o = res_q.redirect_pc;
   assign illegal_o     = res_q.flags.illegal;
   assign br_cnt_o      = br_cnt_q;
   assign miss_cnt_o    = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed + randomised bench for branch_resolve_unit with an expected-result queue.
module tb_branch_resolve_unit;

   localparam int XLEN  = 32;
   localparam int CNT_W = 32;

   typedef struct {
      logic        taken;
      logic [31:0] target;
      logic [31:0] link;
      logic        misp;
      logic [31:0] redir;
      logic        ill;
   } exp_t;

   logic        clk;
   logic        rst_i;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] rs1_i, rs2_i, pc_i, imm_i, pred_target_i;
   logic [2:0]  bcu_op_i;
   logic        is_jal_i, is_jalr_i, pred_taken_i, flush_i;
   logic        valid_o, ready_i, taken_o, mispredict_o, illegal_o;
   logic [31:0] target_o, link_o, redirect_pc_o;
   logic [31:0] br_cnt_o, miss_cnt_o;

   exp_t        exp_q[$];
   exp_t        cur;
   logic        exp_valid;
   logic [31:0] exp_br, exp_miss;
   int          n_cmp;
   int          n_err;

   branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .rs1_i         (rs1_i),
      .rs2_i         (rs2_i),
      .pc_i          (pc_i),
      .imm_i         (imm_i),
      .bcu_op_i      (bcu_op_i),
      .is_jal_i      (is_jal_i),
      .is_jalr_i     (is_jalr_i),
      .pred_taken_i  (pred_taken_i),
      .pred_target_i (pred_target_i),
      .flush_i       (flush_i),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .taken_o       (taken_o),
      .target_o      (target_o),
      .link_o        (link_o),
      .mispredict_o  (mispredict_o),
      .redirect_pc_o (redirect_pc_o),
      .illegal_o     (illegal_o),
      .br_cnt_o      (br_cnt_o),
      .miss_cnt_o    (miss_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk(input logic t, input logic [31:0] tg, input logic [31:0] lk,
                               input logic m, input logic [31:0] rd, input logic il);
      exp_t e;
      e.taken = t; e.target = tg; e.link = lk; e.misp = m; e.redir = rd; e.ill = il;
      return e;
   endfunction

   // Reference behaviour written straight from the instruction semantics
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                                  input logic [31:0] imm, input logic [2:0] op, input logic jal,
                                  input logic jalr, input logic pt, input logic [31:0] ptgt);
      exp_t e;
      e.ill = 1'b0;
      case (op)
         3'd0: e.taken = (a == b);
         3'd1: e.taken = (a != b);
         3'd4: e.taken = ($signed(a) <  $signed(b));
         3'd5: e.taken = ($signed(a) >= $signed(b));
         3'd6: e.taken = (a <  b);
         3'd7: e.taken = (a >= b);
         default: begin e.taken = 1'b0; e.ill = 1'b1; end
      endcase
      if (jal || jalr) begin e.taken = 1'b1; e.ill = 1'b0; end
      e.target = jalr ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
      e.link   = pc + 32'd4;
      e.misp   = (e.taken != pt) || (e.taken && (e.target != ptgt));
      e.redir  = e.taken ? e.target : e.link;
      return e;
   endfunction

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [2:0] op, input logic jal,
                        input logic jalr, input logic pt, input logic [31:0] ptgt, input exp_t e);
      rs1_i = a; rs2_i = b; pc_i = pc; imm_i = imm; bcu_op_i = op;
      is_jal_i = jal; is_jalr_i = jalr; pred_taken_i = pt; pred_target_i = ptgt;
      valid_i = 1'b1;
      exp_q.push_back(e);
   endtask

   // Advance one edge, updating the expected stage/counter state from the inputs presented.
   task automatic tick(input string tag);
      logic retire, load;
      exp_t dropped;
      retire = 1'b0;
      load   = 1'b0;
      if (rst_i) begin
         exp_valid = 1'b0; exp_br = '0; exp_miss = '0;
         exp_q.delete();
      end else begin
         retire = exp_valid && ready_i && !flush_i;
         load   = valid_i && (!exp_valid || ready_i) && !flush_i;
         if (retire) begin
            if (exp_br != '1) exp_br++;
            if (cur.misp && exp_miss != '1) exp_miss++;
         end
         if (valid_i && flush_i && exp_q.size() > 0) dropped = exp_q.pop_front();
         if (load) begin
            if (exp_q.size() == 0) chk({tag, ".queue_empty"}, 64'd1, 64'd0);
            else cur = exp_q.pop_front();
            exp_valid = 1'b1;
         end else if (flush_i || ready_i) begin
            exp_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      if (load) valid_i = 1'b0;
      chk({tag, ".valid_o"},    valid_o,    exp_valid);
      chk({tag, ".ready_o"},    ready_o,    !exp_valid || ready_i);
      chk({tag, ".br_cnt"},     br_cnt_o,   exp_br);
      chk({tag, ".miss_cnt"},   miss_cnt_o, exp_miss);
      if (exp_valid) begin
         chk({tag, ".taken"},    taken_o,       cur.taken);
         chk({tag, ".target"},   target_o,      cur.target);
         chk({tag, ".link"},     link_o,        cur.link);
         chk({tag, ".misp"},     mispredict_o,  cur.misp);
         chk({tag, ".redirect"}, redirect_pc_o, cur.redir);
         chk({tag, ".illegal"},  illegal_o,     cur.ill);
      end
   endtask

   task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] op,
                       input logic jal, input logic jalr, input logic pt,
                       input logic [31:0] ptgt, input exp_t e);
      drive(a, b, pc, imm, op, jal, jalr, pt, ptgt, e);
      tick(tag);
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      exp_valid = 1'b0; exp_br = '0; exp_miss = '0;
      cur = mk(1'b0, '0, '0, 1'b0, '0, 1'b0);
      rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0;
      rs1_i = '0; rs2_i = '0; pc_i = '0; imm_i = '0; bcu_op_i = '0;
      is_jal_i = 1'b0; is_jalr_i = 1'b0; pred_taken_i = 1'b0; pred_target_i = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.valid_o",  valid_o,       1'b0);
      chk("rst.ready_o",  ready_o,       1'b1);
      chk("rst.taken",    taken_o,       1'b0);
      chk("rst.target",   target_o,      32'h0);
      chk("rst.link",     link_o,        32'h0);
      chk("rst.misp",     mispredict_o,  1'b0);
      chk("rst.redirect", redirect_pc_o, 32'h0);
      chk("rst.illegal",  illegal_o,     1'b0);
      chk("rst.br_cnt",   br_cnt_o,      32'h0);
      chk("rst.miss_cnt", miss_cnt_o,    32'h0);
      rst_i = 1'b0;

      // Directed vectors, back to back at full throughput
      send("blt", 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 3'b100, 1'b0, 1'b0, 1'b0, 32'h0,
           mk(1'b1, 32'h120, 32'h104, 1'b1, 32'h120, 1'b0));
      send("bltu", 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 3'b110, 1'b0, 1'b0, 1'b0, 32'h0,
           mk(1'b0, 32'h120, 32'h104, 1'b0, 32'h104, 1'b0));
      send("jalr", 32'h1001, 32'h0, 32'h200, 32'h10, 3'b000, 1'b0, 1'b1, 1'b1, 32'h1010,
           mk(1'b1, 32'h1010, 32'h204, 1'b0, 32'h1010, 1'b0));
      send("rsvd", 32'h5, 32'h5, 32'h300, 32'h40, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0,
           mk(1'b0, 32'h340, 32'h304, 1'b0, 32'h304, 1'b1));
      send("beq_wrap", 32'h7, 32'h7, 32'hFFFF_FFFC, 32'h8, 3'b000, 1'b0, 1'b0, 1'b1, 32'h8,
           mk(1'b1, 32'h4, 32'h0, 1'b1, 32'h4, 1'b0));
      send("jal_jalr", 32'h2000, 32'h0, 32'h400, 32'h3, 3'b011, 1'b1, 1'b1, 1'b1, 32'h2002,
           mk(1'b1, 32'h2002, 32'h404, 1'b0, 32'h2002, 1'b0));
      send("bge", 32'h1, 32'hFFFF_FFFF, 32'h500, 32'hFFFF_FFF0, 3'b101, 1'b0, 1'b0, 1'b0, 32'h0,
           mk(1'b1, 32'h4F0, 32'h504, 1'b1, 32'h4F0, 1'b0));
      send("bgeu", 32'h1, 32'hFFFF_FFFF, 32'h500, 32'hFFFF_FFF0, 3'b111, 1'b0, 1'b0, 1'b1, 32'h4F0,
           mk(1'b0, 32'h4F0, 32'h504, 1'b1, 32'h504, 1'b0));
      send("bne", 32'h3, 32'h4, 32'h600, 32'h80, 3'b001, 1'b0, 1'b0, 1'b1, 32'h680,
           mk(1'b1, 32'h680, 32'h604, 1'b0, 32'h680, 1'b0));
      tick("drain");

      // Randomised ops checked against the reference model
      for (int i = 0; i < 24; i++) begin
         logic [31:0] a, b, pc, imm, ptgt;
         logic [2:0]  op;
         logic        jal, jalr, pt;
         exp_t        e;
         a    = $urandom_range(0, 3) == 0 ? b : $urandom;
         b    = $urandom_range(0, 1) ? $urandom : a;
         pc   = $urandom & 32'hFFFF_FFFC;
         imm  = $urandom;
         op   = 3'($urandom_range(0, 7));
         jal  = ($urandom_range(0, 5) == 0);
         jalr = ($urandom_range(0, 5) == 0);
         pt   = 1'($urandom_range(0, 1));
         e    = model(a, b, pc, imm, op, jal, jalr, pt, 32'h0);
         ptgt = $urandom_range(0, 1) ? e.target : $urandom;
         e    = model(a, b, pc, imm, op, jal, jalr, pt, ptgt);
         send("rand", a, b, pc, imm, op, jal, jalr, pt, ptgt, e);
      end
      tick("rand_drain");

      // Backpressure: A is held for three cycles while B waits at the input
      ready_i = 1'b0;
      send("bp_a", 32'h9, 32'h9, 32'h700, 32'h10, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0,
           mk(1'b1, 32'h710, 32'h704, 1'b1, 32'h710, 1'b0));
      drive(32'h9, 32'h8, 32'h800, 32'h10, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0,
            mk(1'b0, 32'h810, 32'h804, 1'b0, 32'h804, 1'b0));
      repeat (3) tick("bp_stall");
      ready_i = 1'b1;
      tick("bp_b");
      tick("bp_drain");

      // Flush kills both the held result and the incoming one
      send("fl_c", 32'h1, 32'h2, 32'h900, 32'h20, 3'b110, 1'b0, 1'b0, 1'b0, 32'h0,
           mk(1'b1, 32'h920, 32'h904, 1'b1, 32'h920, 1'b0));
      drive(32'h1, 32'h1, 32'hA00, 32'h20, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0,
            mk(1'b1, 32'hA20, 32'hA04, 1'b1, 32'hA20, 1'b0));
      flush_i = 1'b1;
      tick("flush");
      flush_i = 1'b0;
      valid_i = 1'b0;
      tick("post_flush");

      // Saturation: counters preloaded to all-ones stay there after a mispredicting retire
      force dut.br_cnt_q   = 32'hFFFF_FFFF;
      force dut.miss_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.br_cnt_q;
      release dut.miss_cnt_q;
      exp_br   = 32'hFFFF_FFFF;
      exp_miss = 32'hFFFF_FFFF;
      send("sat", 32'h0, 32'h0, 32'hB00, 32'h40, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0,
           mk(1'b1, 32'hB40, 32'hB04, 1'b1, 32'hB40, 1'b0));
      tick("sat_retire");

      // Reset while a result is stalled drops it without counting
      ready_i = 1'b0;
      send("rst_mid_load", 32'h3, 32'h3, 32'hC00, 32'h8, 3'b000, 1'b0, 1'b0, 1'b1, 32'hC08,
           mk(1'b1, 32'hC08, 32'hC04, 1'b0, 32'hC08, 1'b0));
      rst_i = 1'b1;
      tick("rst_mid");
      rst_i   = 1'b0;
      ready_i = 1'b1;
      tick("after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
